wb_initiator: RTL and testbench
===============================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, bus cycles to wait for wb_ack_i/wb_err_i before aborting a beat.
REQ-002 clk_i  input  1  sole clock; Wishbone and request/response sides are synchronous to it.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  command valid.
REQ-005 req_ready_o  output  1  command accepted when high with req_valid_i.
REQ-006 req_we_i  input  1  1 = write burst, 0 = read burst.
REQ-007 req_adr_i  input  32  start byte address; bits [1:0] ignored, forced 0 on the bus.
REQ-008 req_sel_i  input  4  byte enables, applied to every beat.
REQ-009 req_len_i  input  8  beats minus one (0 = 1 beat, 255 = 256 beats).
REQ-010 wdat_valid_i / wdat_ready_o / wdat_i  input / output / 32  write-data stream, one word per write beat.
REQ-011 rsp_valid_o / rsp_ready_i  output / input  1 / 1  per-beat response handshake.
REQ-012 rsp_dat_o  output  32  read data (0 for write beats).
REQ-013 rsp_err_o, rsp_timeout_o, rsp_last_o  output  1 each  beat got wb_err_i; beat timed out; final response of command.
REQ-014 wb_adr_o, wb_dat_o  output  32 each; wb_dat_i  input  32; wb_sel_o  output  4; wb_we_o, wb_stb_o, wb_cyc_o  output  1 each; wb_ack_i, wb_err_i  input  1 each  classic Wishbone initiator port.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 States: IDLE, WDATA, BUS, RESP; all Wishbone outputs and rsp_* driven from registers.
REQ-017 IDLE: req_ready_o=1; on req_valid_i latch we/adr/sel/len, clear beat counter; next WDATA if write else BUS.
REQ-018 WDATA: wdat_ready_o=1; on wdat_valid_i latch wdat_i into wb_dat_o, next BUS; wdat_ready_o=0 in all other states.
REQ-019 BUS: wb_cyc_o=wb_stb_o=1, wb_we_o=latched we, wb_adr_o={addr[31:2],2'b00}; first cycle of BUS is the cycle after entry.
REQ-020 BUS exit on first cycle with wb_ack_i or wb_err_i or timeout counter = TIMEOUT_CYCLES; cyc/stb low the following cycle; capture wb_dat_i on read ack.
REQ-021 wb_ack_i and wb_err_i in the same cycle: treated as error (rsp_err_o=1, data 0).
REQ-022 Timeout counter clears on BUS entry, increments each BUS cycle; timeout sets rsp_err_o=1 and rsp_timeout_o=1.
REQ-023 RESP: rsp_valid_o held high with stable rsp_* until rsp_ready_i; rsp_last_o=1 when beat counter = len or beat errored.
REQ-024 On RESP handshake: if rsp_last_o -> IDLE; else addr += 4 (mod 2^32 wrap), beat counter += 1, next WDATA (write) or BUS (read).
REQ-025 Error/timeout aborts remaining beats; no further Wishbone cycles for that command; unconsumed write data stays in the upstream stream.
REQ-026 wb_cyc_o drops between beats (RESP, WDATA), so each beat is an independent single transfer; no back-to-back strobes.
REQ-027 req_valid_i ignored while busy_o=1; wb_ack_i/wb_err_i ignored outside BUS.

Reset
REQ-028 rstn_i low forces, asynchronously: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, rsp_valid_o=0, rsp_*=0, wdat_ready_o=0, busy_o=0; req_ready_o=1 after release.
REQ-029 Reset mid-transfer abandons the command; no response issued.

Verification
REQ-030 Read, adr=0x0000_0800, len=0, responder acks 1 cycle after stb with 0x1234_5678 -> one response, rsp_dat_o=0x1234_5678, rsp_last_o=1, err=0.
REQ-031 Write, adr=0x0000_0FFC, len=3, data 1..4, rsp_ready_i held 0 for 5 cycles on beat 2 -> bus addresses 0xFFC,0x1000,0x1004,0x1008 with data 1..4; rsp stable while stalled; last only on beat 4.
REQ-032 Read, len=2, wb_err_i on beat 2 -> beats 1,2 responded, beat 2 err=1,last=1; no third cycle on bus.
REQ-033 Read, TIMEOUT_CYCLES=8, no ack -> stb high exactly 9 cycles, rsp_err_o=1, rsp_timeout_o=1, rsp_last_o=1.
REQ-034 adr=0xFFFF_FFFC, len=1 read -> second beat address 0x0000_0000.
REQ-035 rstn_i asserted while wb_stb_o=1 -> cyc/stb low same cycle, no rsp_valid_o; new command after release completes normally.

Source files
------------

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: turns a burst command (read or write, 1..256 beats)
// into a sequence of independent single Wishbone transfers, one response per beat.
// Errors and timeouts abort the rest of the burst.
module wb_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // command
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [3:0]  req_sel_i,
  input  logic [7:0]  req_len_i,
  // write data stream
  input  logic        wdat_valid_i,
  output logic        wdat_ready_o,
  input  logic [31:0] wdat_i,
  // per-beat response
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        rsp_last_o,
  // Wishbone
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  // counter must be able to reach TIMEOUT_CYCLES itself
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WDATA, BUS, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [29:0]   adr_q, adr_d;      // word address; byte offset is always 0 on the bus
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          cyc_q, cyc_d;      // drives both cyc and stb: single transfers only
  logic          wbwe_q, wbwe_d;
  logic          rvld_q, rvld_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          rerr_q, rerr_d;
  logic          rtmo_q, rtmo_d;
  logic          rlast_q, rlast_d;

  logic          tmo_hit, bus_done, beat_err;

  assign tmo_hit  = (tmo_q == TMO_MAX);
  assign bus_done = wb_ack_i | wb_err_i | tmo_hit;
  // ack wins over a coincident timeout; err wins over a coincident ack
  assign beat_err = wb_err_i | (~wb_ack_i & tmo_hit);

  // next-state and next-output computation for the burst sequencer
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    len_d   = len_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    wdat_d  = wdat_q;
    cyc_d   = cyc_q;
    wbwe_d  = wbwe_q;
    rvld_d  = rvld_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    rtmo_d  = rtmo_q;
    rlast_d = rlast_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d   = req_we_i;
          adr_d  = req_adr_i[31:2];
          sel_d  = req_sel_i;
          len_d  = req_len_i;
          beat_d = 8'd0;
          if (req_we_i) begin
            state_d = WDATA;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            wbwe_d  = 1'b0;
            tmo_d   = '0;
          end
        end
      end
      WDATA: begin
        if (wdat_valid_i) begin
          wdat_d  = wdat_i;
          state_d = BUS;
          cyc_d   = 1'b1;
          wbwe_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      BUS: begin
        if (bus_done) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          wbwe_d  = 1'b0;
          rvld_d  = 1'b1;
          rerr_d  = beat_err;
          rtmo_d  = ~wb_ack_i & ~wb_err_i;
          rdat_d  = (wb_ack_i & ~wb_err_i & ~we_q) ? wb_dat_i : 32'd0;
          rlast_d = (beat_q == len_q) | beat_err;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rvld_d = 1'b0;
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            adr_d  = adr_q + 30'd1;
            beat_d = beat_q + 8'd1;
            if (we_q) begin
              state_d = WDATA;
            end else begin
              state_d = BUS;
              cyc_d   = 1'b1;
              tmo_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs; reset abandons any command in flight
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      wdat_q  <= '0;
      cyc_q   <= 1'b0;
      wbwe_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      rtmo_q  <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      wdat_q  <= wdat_d;
      cyc_q   <= cyc_d;
      wbwe_q  <= wbwe_d;
      rvld_q  <= rvld_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      rtmo_q  <= rtmo_d;
      rlast_q <= rlast_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign wdat_ready_o  = (state_q == WDATA);
  assign busy_o        = (state_q != IDLE);
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = wbwe_q;
  assign wb_adr_o      = {adr_q, 2'b00};
  assign wb_sel_o      = sel_q;
  assign wb_dat_o      = wdat_q;
  assign rsp_valid_o   = rvld_q;
  assign rsp_dat_o     = rdat_q;
  assign rsp_err_o     = rerr_q;
  assign rsp_timeout_o = rtmo_q;
  assign rsp_last_o    = rlast_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a burst-level model predicts every bus beat and every
// response; a negedge monitor checks the DUT against it, and directed commands
// add literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_wb_initiator;
  localparam int TMO = 8;

  logic        clk_i = 1'b0, rstn_i = 1'b1;
  logic        req_valid_i = 0, req_we_i = 0;
  logic [31:0] req_adr_i = 0;
  logic [3:0]  req_sel_i = 0;
  logic [7:0]  req_len_i = 0;
  logic        wdat_valid_i = 0;
  logic [31:0] wdat_i = 0;
  logic        rsp_ready_i = 1;
  logic [31:0] wb_dat_i = 0;
  logic        wb_ack_i = 0, wb_err_i = 0;
  logic        req_ready_o, wdat_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_last_o;
  logic [31:0] rsp_dat_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, busy_o;

  always #5 clk_i = ~clk_i;

  wb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_len_i(req_len_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .rsp_last_o(rsp_last_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .busy_o(busy_o)
  );

  typedef struct {logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int len;} bus_t;
  typedef struct {logic [31:0] dat; logic err; logic tmo; logic last;} rsp_t;
  // kind: 0 ack, 1 err, 2 ack+err together, 3 never answer
  typedef struct {int kind; int dly;} mode_t;

  bus_t        exp_bus[$];
  rsp_t        exp_rsp[$];
  mode_t       modes[$];
  mode_t       cm[$];
  logic [31:0] cw[$];
  logic [31:0] wq[$];
  logic [31:0] obs_adr[$], obs_wd[$];
  int          obs_len[$];
  rsp_t        obs_rsp[$];
  int          total = 0, bad = 0;
  int          stall_at = -1, stall_left = 0, rsp_idx = 0, stall_seen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not expected / bound expired", nm);
  endtask

  // slave memory contents
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h0000_0800) ? 32'h1234_5678 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic add_mode(input int kind, input int dly);
    mode_t m;
    m.kind = kind;
    m.dly  = dly;
    cm.push_back(m);
  endtask

  // burst-level prediction: one single transfer per beat, stop after the first failing beat
  task automatic model_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel, input int len);
    logic [31:0] a;
    bus_t b;
    rsp_t r;
    for (int i = 0; i <= len; i++) begin
      a     = {adr[31:2], 2'b00} + 32'(4 * i);
      b.adr = a;
      b.we  = we;
      b.sel = sel;
      b.dat = we ? cw[i] : 32'h0;
      b.len = (cm[i].kind == 3) ? TMO + 1 : cm[i].dly + 1;
      r.err  = (cm[i].kind != 0);
      r.tmo  = (cm[i].kind == 3);
      r.dat  = (cm[i].kind == 0 && !we) ? mem_rd(a) : 32'h0;
      r.last = (i == len) || r.err;
      exp_bus.push_back(b);
      exp_rsp.push_back(r);
      modes.push_back(cm[i]);
      if (r.last) break;
    end
  endtask

  // Wishbone slave: answers each strobe per the queued mode
  initial begin : responder
    int cnt;
    mode_t m;
    logic act;
    act = 0; cnt = 0; m.kind = 3; m.dly = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!(wb_cyc_o && wb_stb_o)) begin
        act = 0; wb_ack_i = 0; wb_err_i = 0;
      end else begin
        if (!act) begin
          act = 1; cnt = 0;
          if (modes.size() > 0) m = modes.pop_front();
          else begin m.kind = 3; m.dly = 0; end
        end else cnt++;
        wb_dat_i = mem_rd(wb_adr_o);
        if (m.kind != 3 && cnt == m.dly) begin
          wb_ack_i = (m.kind == 0 || m.kind == 2);
          wb_err_i = (m.kind == 1 || m.kind == 2);
        end else begin
          wb_ack_i = 0; wb_err_i = 0;
        end
      end
    end
  end

  // write-data stream source
  initial begin : wdat_drv
    logic hs;
    forever begin
      @(negedge clk_i);
      hs = wdat_valid_i && wdat_ready_o && rstn_i;
      @(posedge clk_i); #1;
      if (hs && wq.size() > 0) wq.delete(0);
      wdat_valid_i = (wq.size() > 0);
      wdat_i       = (wq.size() > 0) ? wq[0] : 32'h0;
    end
  end

  // response sink with an optional stall on one response index
  initial begin : rsp_drv
    forever begin
      @(posedge clk_i); #1;
      if (rsp_valid_o && rsp_idx == stall_at && stall_left > 0) begin
        rsp_ready_i = 0;
        stall_left--;
      end else rsp_ready_i = 1;
    end
  end

  // compare process
  initial begin : monitor
    logic stb_prev;
    int slen;
    bus_t cb;
    rsp_t o;
    stb_prev = 0; slen = 0;
    cb.len = 0; cb.adr = 0; cb.we = 0; cb.sel = 0; cb.dat = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        stb_prev = 0; slen = 0;
      end else begin
        if (wb_stb_o !== wb_cyc_o) check("cyc_eq_stb", wb_cyc_o, wb_stb_o);
        if (wb_stb_o) begin
          if (!stb_prev) begin
            obs_adr.push_back(wb_adr_o);
            obs_wd.push_back(wb_dat_o);
            if (exp_bus.size() == 0) flag("bus_unexpected");
            else begin
              cb = exp_bus.pop_front();
              check("bus_adr", wb_adr_o, cb.adr);
              check("bus_we", wb_we_o, cb.we);
              check("bus_sel", wb_sel_o, cb.sel);
              if (cb.we) check("bus_wdat", wb_dat_o, cb.dat);
            end
            slen = 0;
          end
          slen++;
        end else if (stb_prev) begin
          obs_len.push_back(slen);
          check("stb_len", slen, cb.len);
        end
        stb_prev = wb_stb_o;
        if (rsp_valid_o) begin
          if (exp_rsp.size() == 0) flag("rsp_unexpected");
          else begin
            check("rsp_dat", rsp_dat_o, exp_rsp[0].dat);
            check("rsp_err", rsp_err_o, exp_rsp[0].err);
            check("rsp_tmo", rsp_timeout_o, exp_rsp[0].tmo);
            check("rsp_last", rsp_last_o, exp_rsp[0].last);
          end
          if (rsp_ready_i) begin
            o.dat = rsp_dat_o; o.err = rsp_err_o; o.tmo = rsp_timeout_o; o.last = rsp_last_o;
            obs_rsp.push_back(o);
            if (exp_rsp.size() > 0) exp_rsp.delete(0);
            rsp_idx++;
          end else stall_seen++;
        end
      end
    end
  end

  task automatic clear_obs();
    obs_adr.delete(); obs_wd.delete(); obs_len.delete(); obs_rsp.delete();
    rsp_idx = 0; stall_seen = 0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [7:0] len);
    int n;
    @(posedge clk_i); #1;
    req_valid_i = 1; req_we_i = we; req_adr_i = adr; req_sel_i = sel; req_len_i = len;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) flag("req_accept_timeout");
    @(posedge clk_i); #1;
    req_valid_i = 0;
  endtask

  task automatic send(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [7:0] len);
    int n;
    model_cmd(we, adr, sel, int'(len));
    if (we) foreach (cw[i]) wq.push_back(cw[i]);
    clear_obs();
    drive_req(we, adr, sel, len);
    n = 0;
    while ((exp_rsp.size() > 0 || busy_o) && n < 3000) begin @(negedge clk_i); n++; end
    if (n >= 3000) flag("cmd_done_timeout");
    check("bus_beats_all_issued", exp_bus.size(), 0);
    check("idle_req_ready", req_ready_o, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nl;
    #2 rstn_i = 0;
    #1;
    check("rst_cyc", wb_cyc_o, 0);       check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);         check("rst_adr", wb_adr_o, 0);
    check("rst_wdat", wb_dat_o, 0);      check("rst_sel", wb_sel_o, 0);
    check("rst_rvld", rsp_valid_o, 0);   check("rst_rdat", rsp_dat_o, 0);
    check("rst_rerr", rsp_err_o, 0);     check("rst_rtmo", rsp_timeout_o, 0);
    check("rst_rlast", rsp_last_o, 0);   check("rst_wrdy", wdat_ready_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1;
    @(negedge clk_i);
    check("rel_req_ready", req_ready_o, 1);

    // single-beat read, slave acks one cycle after strobe
    cm.delete(); cw.delete(); add_mode(0, 1);
    send(0, 32'h0000_0800, 4'hF, 8'd0);
    check("t1_nrsp", obs_rsp.size(), 1);
    check("t1_dat", obs_rsp[0].dat, 32'h1234_5678);
    check("t1_last", obs_rsp[0].last, 1);
    check("t1_err", obs_rsp[0].err, 0);
    check("t1_stblen", obs_len[0], 2);

    // 4-beat write across a 4 KB line, response 2 stalled 5 cycles
    cm.delete(); cw.delete();
    for (int i = 0; i < 4; i++) begin add_mode(0, 0); cw.push_back(32'(i + 1)); end
    stall_at = 1; stall_left = 5;
    send(1, 32'h0000_0FFC, 4'hF, 8'd3);
    stall_at = -1;
    check("t2_adr0", obs_adr[0], 32'h0000_0FFC);
    check("t2_adr1", obs_adr[1], 32'h0000_1000);
    check("t2_adr2", obs_adr[2], 32'h0000_1004);
    check("t2_adr3", obs_adr[3], 32'h0000_1008);
    for (int i = 0; i < 4; i++) check("t2_wdat", obs_wd[i], 32'(i + 1));
    check("t2_stall", stall_seen, 5);
    nl = 0;
    foreach (obs_rsp[i]) if (obs_rsp[i].last) nl++;
    check("t2_nlast", nl, 1);
    check("t2_last4", obs_rsp[3].last, 1);

    // 3-beat read, error on beat 2 aborts beat 3
    cm.delete(); cw.delete(); add_mode(0, 0); add_mode(1, 2); add_mode(0, 0);
    send(0, 32'h0000_2000, 4'hF, 8'd2);
    check("t3_nrsp", obs_rsp.size(), 2);
    check("t3_nbus", obs_adr.size(), 2);
    check("t3_err", obs_rsp[1].err, 1);
    check("t3_last", obs_rsp[1].last, 1);

    // silent slave: timeout after TMO+1 strobe cycles
    cm.delete(); cw.delete(); add_mode(3, 0); add_mode(0, 0);
    send(0, 32'h0000_3000, 4'h1, 8'd1);
    check("t4_stblen", obs_len[0], 9);
    check("t4_tmo", obs_rsp[0].tmo, 1);
    check("t4_err", obs_rsp[0].err, 1);
    check("t4_last", obs_rsp[0].last, 1);
    check("t4_nrsp", obs_rsp.size(), 1);

    // address wrap at top of memory, low address bits ignored
    cm.delete(); cw.delete(); add_mode(0, 0); add_mode(0, 3);
    send(0, 32'hFFFF_FFFF, 4'h3, 8'd1);
    check("t5_adr0", obs_adr[0], 32'hFFFF_FFFC);
    check("t5_adr1", obs_adr[1], 32'h0000_0000);
    check("t5_dat1", obs_rsp[1].dat, 32'h5A5A_0000);

    // ack and err together count as error with no data
    cm.delete(); cw.delete(); add_mode(2, 1);
    send(0, 32'h0000_4000, 4'hF, 8'd0);
    check("t6_err", obs_rsp[0].err, 1);
    check("t6_dat", obs_rsp[0].dat, 0);

    // aborted write leaves its unused word upstream
    cm.delete(); cw.delete(); add_mode(0, 0); add_mode(1, 0); add_mode(0, 0);
    cw.push_back(32'hAAAA_0001); cw.push_back(32'hAAAA_0002); cw.push_back(32'hAAAA_0003);
    send(1, 32'h0000_5000, 4'hC, 8'd2);
    check("t7_left", wq.size(), 1);
    check("t7_leftword", wq[0], 32'hAAAA_0003);
    wq.delete();
    repeat (2) @(negedge clk_i);

    // reset while strobing
    cm.delete(); cw.delete(); add_mode(3, 0);
    model_cmd(0, 32'h0000_7000, 4'hF, 0);
    clear_obs();
    drive_req(0, 32'h0000_7000, 4'hF, 8'd0);
    nl = 0;
    while (!wb_stb_o && nl < 20) begin @(negedge clk_i); nl++; end
    if (nl >= 20) flag("t8_no_stb");
    @(negedge clk_i); #2;
    rstn_i = 0;
    #1;
    check("t8_cyc", wb_cyc_o, 0);
    check("t8_stb", wb_stb_o, 0);
    check("t8_busy", busy_o, 0);
    exp_bus.delete(); exp_rsp.delete(); modes.delete();
    for (int i = 0; i < 3; i++) begin @(negedge clk_i); check("t8_norsp", rsp_valid_o, 0); end
    rstn_i = 1;
    repeat (2) @(negedge clk_i);
    check("t8_norsp_after", obs_rsp.size(), 0);

    cm.delete(); cw.delete(); add_mode(0, 0); add_mode(0, 1);
    cw.push_back(32'hBEEF_0001); cw.push_back(32'hBEEF_0002);
    send(1, 32'h0000_6000, 4'hF, 8'd1);
    check("t9_nrsp", obs_rsp.size(), 2);
    check("t9_adr1", obs_adr[1], 32'h0000_6004);
    check("t9_last", obs_rsp[1].last, 1);

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
